// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port between NUM_PORTS
// valid/ready requester streams. A granted requester may keep the port for up
// to MAX_BURST consecutive beats. After that, or as soon as it stops
// presenting data, the grant moves on. The output is a single register stage
// that feeds the FIFO write side directly.
//
// Optional feature (macro FIFO_WR_ARB_TAG_EN):
//   When defined, outDataOut is {sourceIdx, data} (DATA_WIDTH+IDX_WIDTH bits).
//   When undefined, outDataOut carries the data word only.
//
// Ports:
//   clkIn        clock, single domain
//   rstIn        synchronous active-high reset
//   reqDataIn    requester data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqValidIn   per-requester valid
//   reqReadyOut  per-requester ready (combinational, at most one bit high)
//   outDataOut   registered data to FIFO wrDataIn
//   outValidOut  registered valid to FIFO wrValidIn
//   outReadyIn   FIFO wrReadyOut
//   grantIdxOut  index of the current or last owner (debug)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_PORTS  = 4,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int OUT_WIDTH  = DATA_WIDTH + IDX_WIDTH
`else
    localparam int OUT_WIDTH  = DATA_WIDTH
`endif
) (
    input  logic                            clkIn,
    input  logic                            rstIn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reqDataIn,
    input  logic [NUM_PORTS-1:0]            reqValidIn,
    output logic [NUM_PORTS-1:0]            reqReadyOut,
    output logic [OUT_WIDTH-1:0]            outDataOut,
    output logic                            outValidOut,
    input  logic                            outReadyIn,
    output logic [IDX_WIDTH-1:0]            grantIdxOut
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arbState_t;

    arbState_t            state;
    logic [IDX_WIDTH-1:0] rrPtr;
    logic [IDX_WIDTH-1:0] owner;
    logic [BCW-1:0]       burstCnt;

    logic                 ld;
    logic                 lockHit;
    logic [IDX_WIDTH-1:0] searchStart;
    logic                 arbFound;
    logic [IDX_WIDTH-1:0] arbSel;
    logic                 accept;
    logic [IDX_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] selData;

    // Next index with wrap at NUM_PORTS-1 (NUM_PORTS need not be a power of 2).
    function automatic logic [IDX_WIDTH-1:0] wrapInc(input logic [IDX_WIDTH-1:0] idx);
        return (idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First valid requester at or after start, modulo NUM_PORTS.
    // Returns {found, index}. The loop walks backwards so the last hit kept
    // is the one closest to start.
    function automatic logic [IDX_WIDTH:0] rrSearch(
        input logic [NUM_PORTS-1:0] valid,
        input logic [IDX_WIDTH-1:0] start
    );
        logic [IDX_WIDTH:0]   res;
        logic [IDX_WIDTH-1:0] idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = IDX_WIDTH'((int'(start) + k) % NUM_PORTS);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // The output register can take a new beat when empty or draining this cycle.
    assign ld = !outValidOut || outReadyIn;

    // NOTE: every signal written in always_comb gets a default at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        lockHit     = 1'b0;
        searchStart = rrPtr;
        arbFound    = 1'b0;
        arbSel      = '0;
        accept      = 1'b0;
        sel         = '0;

        lockHit = (state == LOCK) && reqValidIn[owner];

        // When the owner drops out of a burst, the search begins just after it.
        searchStart = (state == LOCK) ? wrapInc(owner) : rrPtr;
        {arbFound, arbSel} = rrSearch(reqValidIn, searchStart);

        if (lockHit) begin
            sel    = owner;
            accept = ld;
        end else begin
            sel    = arbSel;
            accept = ld && arbFound;
        end
    end

    always_comb begin
        reqReadyOut = '0;
        selData     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept && (sel == IDX_WIDTH'(i))) reqReadyOut[i] = 1'b1;
            if (sel == IDX_WIDTH'(i)) selData = reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state       <= IDLE;
            rrPtr       <= '0;
            owner       <= '0;
            burstCnt    <= '0;
            outDataOut  <= '0;
            outValidOut <= 1'b0;
            grantIdxOut <= '0;
        end else if (ld) begin
            if (lockHit) begin
                // Continue the burst on the current owner.
`ifdef FIFO_WR_ARB_TAG_EN
                outDataOut <= {owner, selData};
`else
                outDataOut <= selData;
`endif
                outValidOut <= 1'b1;
                burstCnt    <= burstCnt + 1'b1;
                if ((burstCnt + 1'b1) == BCW'(MAX_BURST)) begin
                    state <= IDLE;
                    rrPtr <= wrapInc(owner);
                end
            end else if (arbFound) begin
                // New grant, either from IDLE or released from LOCK with no bubble.
`ifdef FIFO_WR_ARB_TAG_EN
                outDataOut <= {arbSel, selData};
`else
                outDataOut <= selData;
`endif
                outValidOut <= 1'b1;
                owner       <= arbSel;
                grantIdxOut <= arbSel;
                if (MAX_BURST == 1) begin
                    state <= IDLE;
                    rrPtr <= wrapInc(arbSel);
                end else begin
                    state    <= LOCK;
                    burstCnt <= BCW'(1);
                end
            end else begin
                outValidOut <= 1'b0;
                if (state == LOCK) begin
                    state <= IDLE;
                    rrPtr <= wrapInc(owner);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Instance dut uses the default burst
// length of 4; instance dutRr uses MAX_BURST=1. Requesters on dut send words
// {port[3:0], sequence[27:0]} so every expected output word identifies its
// source and beat number. Requesters on dutRr send the constant 0x100+port.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int IW = 2;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int OW = DW + IW;
`else
    localparam int OW = DW;
`endif

    logic           clkIn = 1'b0;
    logic           rstIn;

    logic [NP*DW-1:0] reqDataIn;
    logic [NP-1:0]    reqValidIn;
    logic [NP-1:0]    reqReadyOut;
    logic [OW-1:0]    outDataOut;
    logic             outValidOut;
    logic             outReadyIn;
    logic [IW-1:0]    grantIdxOut;

    logic [NP*DW-1:0] rrDataIn;
    logic [NP-1:0]    rrValidIn;
    logic [NP-1:0]    rrReadyOut;
    logic [OW-1:0]    rrDataOut;
    logic             rrValidOut;
    logic             rrReadyIn;
    logic [IW-1:0]    rrGrantIdxOut;

    int seq [NP];
    int nChecks = 0;
    int nPass   = 0;

    always #5 clkIn = ~clkIn;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .MAX_BURST(4)) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .reqDataIn   (reqDataIn),
        .reqValidIn  (reqValidIn),
        .reqReadyOut (reqReadyOut),
        .outDataOut  (outDataOut),
        .outValidOut (outValidOut),
        .outReadyIn  (outReadyIn),
        .grantIdxOut (grantIdxOut)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .MAX_BURST(1)) dutRr (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .reqDataIn   (rrDataIn),
        .reqValidIn  (rrValidIn),
        .reqReadyOut (rrReadyOut),
        .outDataOut  (rrDataOut),
        .outValidOut (rrValidOut),
        .outReadyIn  (rrReadyIn),
        .grantIdxOut (rrGrantIdxOut)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] srcWord(input int p, input int s);
        return {4'(p), 28'(s)};
    endfunction

    function automatic logic [63:0] expData(input int p, input logic [DW-1:0] d);
`ifdef FIFO_WR_ARB_TAG_EN
        return 64'({IW'(p), d});
`else
        return 64'(d);
`endif
    endfunction

    task automatic updData();
        for (int i = 0; i < NP; i++) reqDataIn[i*DW +: DW] = srcWord(i, seq[i]);
    endtask

    // One clock: capture ready at the falling edge, then advance the source
    // model for every handshake just after the rising edge.
    task automatic tick(output logic [NP-1:0] rdy, output logic [NP-1:0] rdyRr);
        logic [NP-1:0] acc;
        @(negedge clkIn);
        rdy   = reqReadyOut;
        rdyRr = rrReadyOut;
        acc   = reqReadyOut & reqValidIn;
        @(posedge clkIn);
        #1;
        if (!rstIn) begin
            for (int i = 0; i < NP; i++) if (acc[i]) seq[i]++;
        end
        updData();
    endtask

    initial begin
        logic [NP-1:0] rdy;
        logic [NP-1:0] rdyRr;
        int p;

        for (int i = 0; i < NP; i++) seq[i] = 0;
        rstIn      = 1'b1;
        reqValidIn = '0;
        outReadyIn = 1'b1;
        rrValidIn  = '0;
        rrReadyIn  = 1'b1;
        for (int i = 0; i < NP; i++) rrDataIn[i*DW +: DW] = 32'h100 + i;
        updData();

        // Reset state
        tick(rdy, rdyRr);
        tick(rdy, rdyRr);
        check("rst_valid", 64'(outValidOut), 64'd0);
        check("rst_data",  64'(outDataOut),  64'd0);
        check("rst_ready", 64'(rdy),         64'd0);
        check("rst_grant", 64'(grantIdxOut), 64'd0);

        // All four valid, FIFO always ready: 4-beat bursts rotating 0,1,2,3,0
        rstIn      = 1'b0;
        reqValidIn = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            p = (k / 4) % 4;
            tick(rdy, rdyRr);
            check($sformatf("burst_rdy%0d", k), 64'(rdy), 64'(1 << p));
            check($sformatf("burst_vld%0d", k), 64'(outValidOut), 64'd1);
            check($sformatf("burst_dat%0d", k), 64'(outDataOut),
                  expData(p, srcWord(p, (k / 16) * 4 + k % 4)));
        end
        check("burst_grant", 64'(grantIdxOut), 64'd0);

        // p2 takes the port for 2 beats, then drops; p3 wins the same cycle
        reqValidIn = 4'b0100;
        tick(rdy, rdyRr);
        check("drop_p2a", 64'(outDataOut), expData(2, srcWord(2, 4)));
        tick(rdy, rdyRr);
        check("drop_p2b", 64'(outDataOut), expData(2, srcWord(2, 5)));
        reqValidIn = 4'b1001;
        tick(rdy, rdyRr);
        check("drop_rdy",   64'(rdy),         64'b1000);
        check("drop_vld",   64'(outValidOut), 64'd1);
        check("drop_dat",   64'(outDataOut),  expData(3, srcWord(3, 4)));
        check("drop_grant", 64'(grantIdxOut), 64'd3);
        tick(rdy, rdyRr);
        check("lock_p3_rdy", 64'(rdy),        64'b1000);
        check("lock_p3_dat", 64'(outDataOut), expData(3, srcWord(3, 5)));

        // Third p3 beat is 0xA5A5A5A5, then the FIFO stalls for 5 cycles
        reqDataIn[3*DW +: DW] = 32'hA5A5A5A5;
        tick(rdy, rdyRr);
        check("a5_dat", 64'(outDataOut), expData(3, 32'hA5A5A5A5));
        outReadyIn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(rdy, rdyRr);
            check($sformatf("stall_rdy%0d", k), 64'(rdy),         64'd0);
            check($sformatf("stall_vld%0d", k), 64'(outValidOut), 64'd1);
            check($sformatf("stall_dat%0d", k), 64'(outDataOut),  expData(3, 32'hA5A5A5A5));
        end
        // Release: p3 gets exactly its 4th beat, then the pointer wraps to p0
        outReadyIn = 1'b1;
        tick(rdy, rdyRr);
        check("rel_rdy", 64'(rdy),        64'b1000);
        check("rel_dat", 64'(outDataOut), expData(3, srcWord(3, 7)));
        tick(rdy, rdyRr);
        check("wrap_rdy",   64'(rdy),         64'b0001);
        check("wrap_dat",   64'(outDataOut),  expData(0, srcWord(0, 8)));
        check("wrap_grant", 64'(grantIdxOut), 64'd0);

        // p0 drops, p1 takes over for 2 beats, then reset mid-burst
        reqValidIn = 4'b0010;
        tick(rdy, rdyRr);
        check("p1_dat0", 64'(outDataOut), expData(1, srcWord(1, 4)));
        tick(rdy, rdyRr);
        check("p1_dat1", 64'(outDataOut), expData(1, srcWord(1, 5)));
        reqValidIn = 4'b1010;
        rstIn      = 1'b1;
        tick(rdy, rdyRr);
        check("mrst_vld",   64'(outValidOut), 64'd0);
        check("mrst_dat",   64'(outDataOut),  64'd0);
        check("mrst_grant", 64'(grantIdxOut), 64'd0);
        rstIn = 1'b0;
        // Fresh arbitration from pointer 0: p1 gets a full 4-beat burst, then p3
        for (int k = 0; k < 5; k++) begin
            p = (k < 4) ? 1 : 3;
            tick(rdy, rdyRr);
            check($sformatf("post_rdy%0d", k), 64'(rdy), 64'(1 << p));
            check($sformatf("post_dat%0d", k), 64'(outDataOut),
                  expData(p, srcWord(p, (k < 4) ? 6 + k : 8)));
        end
        reqValidIn = '0;

        // MAX_BURST=1: per-beat rotation 0,1,2,3,0,... with one ready bit
        rrValidIn = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            p = k % 4;
            tick(rdy, rdyRr);
            check($sformatf("rr_rdy%0d", k),   64'(rdyRr),         64'(1 << p));
            check($sformatf("rr_dat%0d", k),   64'(rrDataOut),     expData(p, 32'h100 + p));
            check($sformatf("rr_grant%0d", k), 64'(rrGrantIdxOut), 64'(p));
        end
        rrValidIn = '0;
        tick(rdy, rdyRr);
        check("rr_idle_vld", 64'(rrValidOut), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
